// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit with boot hold, fetch handshake and redirect.
// The PC register advances by STEP on an accepted fetch, is loaded from an
// aligned redirect target, or holds for a stall or an unaccepted fetch.
// Optional build macro PC_COMPRESSED_EN adds 16-bit instruction stepping
// (step of 2 when instr_is_rvc_i is set) and relaxes redirect alignment
// to 2 bytes. With the macro undefined, instr_is_rvc_i is ignored and
// redirects are aligned to 4 bytes.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_BOOT | post-reset hold, no fetch issued, redirects ignored
//   ST_RUN  | fetch for pc_o is valid, previous fetch was accepted
//   ST_WAIT | fetch for pc_o is valid, waiting for imem to accept it
module pc_sequencer #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               STEP         = 4,
    parameter int               BOOT_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_target_i,
    input  logic             imem_ready_i,
    input  logic             instr_is_rvc_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus_step_o,
    output logic             fetch_valid_o,
    output logic             misaligned_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // BOOT_CYCLES of 0 and 1 both leave BOOT on the first clock after release,
    // because the reset state is BOOT with fetch_valid_o registered low.
    localparam int BOOT_LAST = (BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0;
    localparam int CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    state_t             state;
    logic [CNT_W-1:0]   boot_cnt;
    logic [XLEN-1:0]    step;
    logic [XLEN-1:0]    target_aligned;
    logic               target_misaligned;
    logic               boot_done;

`ifdef PC_COMPRESSED_EN
    // Compressed instructions advance by a halfword; targets need only halfword alignment.
    always_comb begin
        step              = instr_is_rvc_i ? XLEN'(2) : XLEN'(STEP);
        target_aligned    = {redirect_target_i[XLEN-1:1], 1'b0};
        target_misaligned = redirect_target_i[0];
    end
`else
    // instr_is_rvc_i has no effect in this build.
    logic unused_rvc;
    assign unused_rvc = instr_is_rvc_i;

    // Fixed step; targets are forced onto a word boundary.
    always_comb begin
        step              = XLEN'(STEP);
        target_aligned    = {redirect_target_i[XLEN-1:2], 2'b00};
        target_misaligned = |redirect_target_i[1:0];
    end
`endif

    // Sequential successor, wraps modulo 2^XLEN with the carry dropped.
    always_comb begin
        pc_plus_step_o = pc_o + step;
    end

    // Boot hold is finished once the counter has reached its last value.
    always_comb begin
        boot_done = (boot_cnt == CNT_W'(BOOT_LAST));
    end

    // Sequencer FSM: PC register, fetch request, one-cycle misalignment flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_BOOT;
            boot_cnt      <= '0;
            pc_o          <= RESET_VECTOR;
            fetch_valid_o <= 1'b0;
            misaligned_o  <= 1'b0;
        end else begin
            misaligned_o <= 1'b0;
            case (state)
                ST_BOOT: begin
                    fetch_valid_o <= 1'b0;
                    if (boot_done) begin
                        state         <= ST_RUN;
                        fetch_valid_o <= 1'b1;
                    end else begin
                        boot_cnt <= boot_cnt + CNT_W'(1);
                    end
                end
                ST_RUN, ST_WAIT: begin
                    fetch_valid_o <= 1'b1;
                    if (redirect_valid_i) begin
                        // A redirect abandons any fetch still pending in WAIT.
                        pc_o         <= target_aligned;
                        misaligned_o <= target_misaligned;
                        state        <= ST_RUN;
                    end else if (stall_i) begin
                        // Stall freezes both the PC and the handshake state.
                        pc_o  <= pc_o;
                        state <= state;
                    end else if (imem_ready_i) begin
                        pc_o  <= pc_plus_step_o;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                default: begin
                    state         <= ST_BOOT;
                    boot_cnt      <= '0;
                    fetch_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
// Handles both builds: expectations switch on PC_COMPRESSED_EN.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_target_i;
    logic        imem_ready_i;
    logic        instr_is_rvc_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus_step_o;
    logic        fetch_valid_o;
    logic        misaligned_o;

    int n_checks = 0;
    int n_pass   = 0;

    pc_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .STEP         (4),
        .BOOT_CYCLES  (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .imem_ready_i      (imem_ready_i),
        .instr_is_rvc_i    (instr_is_rvc_i),
        .pc_o              (pc_o),
        .pc_plus_step_o    (pc_plus_step_o),
        .fetch_valid_o     (fetch_valid_o),
        .misaligned_o      (misaligned_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic [31:0] tgt, input logic st, input logic rdy);
        redirect_valid_i  = rd;
        redirect_target_i = tgt;
        stall_i           = st;
        imem_ready_i      = rdy;
    endtask

    initial begin
        rst            = 1'b1;
        instr_is_rvc_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        check("reset_pc", pc_o, 32'h0);
        check("reset_fv", {31'b0, fetch_valid_o}, 32'h0);
        check("reset_mis", {31'b0, misaligned_o}, 32'h0);

        // Boot hold of two clocks; a redirect during BOOT must be ignored.
        rst = 1'b0;
        drive(1'b1, 32'h500, 1'b0, 1'b1);
        tick();
        check("boot1_fv", {31'b0, fetch_valid_o}, 32'h0);
        check("boot1_pc", pc_o, 32'h0);
        tick();
        check("boot2_fv", {31'b0, fetch_valid_o}, 32'h1);
        check("boot2_pc", pc_o, 32'h0);
        check("pc_plus_step", pc_plus_step_o, 32'h4);

        // Redirect to 0x100, then three accepted fetches.
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        check("redir_100", pc_o, 32'h100);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check("seq_104", pc_o, 32'h104);
        tick();
        check("seq_108", pc_o, 32'h108);
        tick();
        check("seq_10c", pc_o, 32'h10C);

        // imem not ready: WAIT, PC held, fetch still requested.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check("wait_pc1", pc_o, 32'h10C);
        tick();
        check("wait_pc2", pc_o, 32'h10C);
        check("wait_fv", {31'b0, fetch_valid_o}, 32'h1);

        // Redirect out of WAIT.
        drive(1'b1, 32'h2000, 1'b0, 1'b0);
        tick();
        check("wait_redir_pc", pc_o, 32'h2000);
        check("wait_redir_mis", {31'b0, misaligned_o}, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check("after_redir_seq", pc_o, 32'h2004);

        // Halfword-offset target.
        drive(1'b1, 32'h2002, 1'b0, 1'b0);
        tick();
`ifdef PC_COMPRESSED_EN
        check("mis2_pc", pc_o, 32'h2002);
        check("mis2_flag", {31'b0, misaligned_o}, 32'h0);
`else
        check("mis2_pc", pc_o, 32'h2000);
        check("mis2_flag", {31'b0, misaligned_o}, 32'h1);
`endif
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check("mis_clear", {31'b0, misaligned_o}, 32'h0);

        // Byte-offset target is misaligned in both builds.
        drive(1'b1, 32'h3001, 1'b0, 1'b0);
        tick();
        check("mis1_pc", pc_o, 32'h3000);
        check("mis1_flag", {31'b0, misaligned_o}, 32'h1);

        // Redirect beats stall; stall then holds PC even with ready high.
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        tick();
        check("stall_redir_pc", pc_o, 32'h40);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        check("stall_hold1", pc_o, 32'h40);
        tick();
        check("stall_hold2", pc_o, 32'h40);

        // Wrap-around at the top of the address space.
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        tick();
        check("top_pc", pc_o, 32'hFFFF_FFFC);
        check("top_plus", pc_plus_step_o, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check("wrap_pc", pc_o, 32'h0);
        check("wrap_mis", {31'b0, misaligned_o}, 32'h0);

        // Compressed-instruction stepping (ignored without the macro).
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        instr_is_rvc_i = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
`ifdef PC_COMPRESSED_EN
        check("rvc_step", pc_o, 32'h12);
`else
        check("rvc_step", pc_o, 32'h14);
`endif
        instr_is_rvc_i = 1'b0;

        // Reset asserted asynchronously in the middle of WAIT.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pc", pc_o, 32'h0);
        check("async_rst_fv", {31'b0, fetch_valid_o}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("reboot_fv1", {31'b0, fetch_valid_o}, 32'h0);
        tick();
        check("reboot_fv2", {31'b0, fetch_valid_o}, 32'h1);
        drive(1'b1, 32'h500, 1'b0, 1'b0);
        tick();
        check("reboot_redir", pc_o, 32'h500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
